pc_sp_sequencer: RTL

//  Parametrised next-generation PC/SP address unit for the cs147sec05 processor.

---
 rtl/pc_sp_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sp_sequencer.sv
// pc_sp_sequencer
// Program counter and stack pointer unit for the cs147sec05 processor.
// It applies the sequential, branch, jump, jump-register and jal PC updates in
// a single cycle. Push and pop run as req/ack memory transactions, and the unit
// refuses stack accesses that would run past either end of the stack.

module pc_sp_sequencer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    IMM_WIDTH   = 16,
    parameter int                    JADDR_WIDTH = 26,
    parameter logic [DATA_WIDTH-1:0] PC_INIT     = 32'h0000_1000,
    parameter logic [DATA_WIDTH-1:0] SP_INIT     = 32'h03FF_FFFF,
    parameter logic [DATA_WIDTH-1:0] SP_LIMIT    = 32'h03FF_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             op,
    input  logic                   valid,
    output logic                   ready,
    input  logic                   taken,
    input  logic [IMM_WIDTH-1:0]   imm,
    input  logic [JADDR_WIDTH-1:0] jaddr,
    input  logic [DATA_WIDTH-1:0]  rs_data,
    output logic [DATA_WIDTH-1:0]  pc,
    output logic [DATA_WIDTH-1:0]  sp,
    output logic [DATA_WIDTH-1:0]  ret_addr,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack,
    output logic [DATA_WIDTH-1:0]  pop_data,
    output logic                   done,
    output logic                   ovf,
    output logic                   unf
);

    typedef enum logic {
        S_IDLE,
        S_MEM
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_SEQ  = 3'd1;
    localparam logic [2:0] OP_BR   = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_JR   = 3'd4;
    localparam logic [2:0] OP_JAL  = 3'd5;
    localparam logic [2:0] OP_PUSH = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_n;
    logic [DATA_WIDTH-1:0]   pc_q, pc_n;
    logic [DATA_WIDTH-1:0]   sp_q, sp_n;
    logic [DATA_WIDTH-1:0]   ret_q, ret_n;
    logic                    we_q, we_n;
    logic [DATA_WIDTH-1:0]   addr_q, addr_n;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [DATA_WIDTH-1:0]   pop_q, pop_n;
    logic                    done_q, done_n;
    logic                    ovf_q, ovf_n;
    logic                    unf_q, unf_n;

    logic [DATA_WIDTH-1:0]   pc_inc;
    logic [DATA_WIDTH-1:0]   imm_sext;
    logic [DATA_WIDTH-1:0]   jaddr_zext;

    assign pc_inc     = pc_q + ONE;
    assign imm_sext   = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign jaddr_zext = {{(DATA_WIDTH-JADDR_WIDTH){1'b0}}, jaddr};

    assign ready     = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_MEM);
    assign pc        = pc_q;
    assign sp        = sp_q;
    assign ret_addr  = ret_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pop_data  = pop_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    // Next-state and datapath updates: ops are accepted only in IDLE, and an ack only completes a transfer in MEM
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        sp_n    = sp_q;
        ret_n   = ret_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        pop_n   = pop_q;
        done_n  = 1'b0;
        ovf_n   = ovf_q;
        unf_n   = unf_q;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    case (op)
                        OP_NOP: begin
                            done_n = 1'b1;
                        end
                        OP_SEQ: begin
                            pc_n   = pc_inc;
                            done_n = 1'b1;
                        end
                        OP_BR: begin
                            pc_n   = taken ? (pc_inc + imm_sext) : pc_inc;
                            done_n = 1'b1;
                        end
                        OP_JMP: begin
                            pc_n   = jaddr_zext;
                            done_n = 1'b1;
                        end
                        OP_JR: begin
                            pc_n   = rs_data;
                            done_n = 1'b1;
                        end
                        OP_JAL: begin
                            ret_n  = pc_inc;
                            pc_n   = jaddr_zext;
                            done_n = 1'b1;
                        end
                        OP_PUSH: begin
                            if (sp_q < SP_LIMIT) begin
                                ovf_n  = 1'b1;
                                pc_n   = pc_inc;
                                done_n = 1'b1;
                            end else begin
                                state_n = S_MEM;
                                we_n    = 1'b1;
                                addr_n  = sp_q;
                                wdata_n = rs_data;
                            end
                        end
                        OP_POP: begin
                            if (sp_q == SP_INIT) begin
                                unf_n  = 1'b1;
                                pc_n   = pc_inc;
                                done_n = 1'b1;
                            end else begin
                                state_n = S_MEM;
                                we_n    = 1'b0;
                                addr_n  = sp_q + ONE;
                            end
                        end
                        default: begin
                            state_n = S_IDLE;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_n = S_IDLE;
                    pc_n    = pc_inc;
                    done_n  = 1'b1;
                    if (we_q) begin
                        sp_n = sp_q - ONE;
                    end else begin
                        sp_n  = sp_q + ONE;
                        pop_n = mem_rdata;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; a low reset drops any transfer still in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_INIT;
            sp_q    <= SP_INIT;
            ret_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pop_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            sp_q    <= sp_n;
            ret_q   <= ret_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            pop_q   <= pop_n;
            done_q  <= done_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
        end
    end

endmodule
